param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
Parametrised successor to the CPU's 32x32 general register file, used by the multicycle datapath's decode/writeback stages.
- Generalised width and depth.
- Synchronous reset clear and optional hardwired-zero register 0.
- Three write-merge modes: full, upper-half (LUI), byte-enable.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard that lets the control FSM stall on pending writebacks.

Parameters:
DATA_WIDTH, 32, register width in bits; must be even and a multiple of 8.
ADDR_WIDTH, 5, select width; depth = 2**ADDR_WIDTH.
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and reserves.
BYPASS, 1, 1 = read ports return the value being written this cycle on an address match.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
read_sel_1  in  ADDR_WIDTH  read port 1 address.
read_sel_2  in  ADDR_WIDTH  read port 2 address.
read_data_1  out  DATA_WIDTH  read port 1 data (combinational).
read_data_2  out  DATA_WIDTH  read port 2 data (combinational).
read_busy_1  out  1  busy bit of read_sel_1 (registered state).
read_busy_2  out  1  busy bit of read_sel_2 (registered state).
RegWrite  in  1  write enable.
write_address  in  ADDR_WIDTH  write target.
write_data  in  DATA_WIDTH  write data.
write_mode  in  2  00 full; 01 upper-half (LUI); 10 byte-enable; 11 reserved, treated as 00.
byte_en  in  DATA_WIDTH/8  byte lanes for mode 10.
reserve  in  1  mark reserve_address busy (pending writeback).
reserve_address  in  ADDR_WIDTH  register to reserve.
busy_any  out  1  OR of all busy bits.

Behaviour:
Reset:
- rst high at a clock edge clears every register to 0 and every busy bit to 0 in that single cycle.
- RegWrite and reserve are ignored in that cycle.
- Outputs become 0 immediately after the edge (read_data_*, read_busy_*, busy_any).
- Before the first reset, contents are undefined; there is no initial block.

Write-merge value (HALF = DATA_WIDTH/2), with old = current contents of write_address:
- Mode 00: write_data.
- Mode 01: {write_data[HALF-1:0], old[HALF-1:0]}. The low half of write_data moves to the upper half; the old lower half is kept.
- Mode 10: per byte lane k, byte_en[k] ? write_data lane k : old lane k. byte_en all zero leaves the register unchanged, but busy is still cleared.

Write commit and zero register:
- The merged value commits at the rising edge when RegWrite=1 and rst=0. Write latency is 1 cycle.
- ZERO_REG=1: writes to address 0 are discarded, register 0 reads 0, and reserve to 0 is ignored.

Reads:
- Combinational from the array; both ports are independent, and both may address the same register.
- BYPASS=1: if RegWrite=1, rst=0, write_address==read_sel_n, and the address is not the zero register, read_data_n is the merged value being written.
- BYPASS=0: read_data_n shows the old value until the edge.

Scoreboard:
- reserve=1 sets busy[reserve_address] at the edge.
- RegWrite=1 clears busy[write_address] at the edge.
- Same address, same cycle: the write data commits and busy ends SET (the new producer wins).
- Different addresses: both actions take effect.
- Reserve of an already-busy register leaves it busy; a write to a non-busy register is legal.
- read_busy_n and busy_any reflect registered busy bits only and are not bypassed.

Other rules:
- No other state; no output latency beyond the above.
- Asserting rst mid-sequence, e.g. reserve then rst before the write, discards the pending reservation.

Test Plan:
1. rst=1 one cycle after random writes -> all 32 registers read 0, busy_any=0; then write 0xDEADBEEF to r5 in mode 00 -> next cycle read_data_1=0xDEADBEEF with read_sel_1=5.
2. r7=0x12345678; write 0x0000ABCD to r7 in mode 01 -> r7=0xABCD5678. Then mode 10, byte_en=4'b0101, data 0xFFFFFFFF -> r7=0xABFF56FF.
3. Write 0x55 to r0 with reserve r0 (ZERO_REG=1) -> r0 reads 0 and read_busy=0. Same test with ZERO_REG=0 -> r0 reads 0x55.
4. BYPASS=1: write 0xCAFEF00D to r3 while read_sel_1=read_sel_2=3 -> both ports show 0xCAFEF00D in the same cycle. BYPASS=0 -> both ports show the old value until the next cycle.
5. reserve r9 -> read_busy=1 and busy_any=1. Same-cycle write r9 with reserve r9 -> busy stays 1. Write r9 alone -> busy 0 and busy_any 0.
6. reserve r4, then rst before the write -> busy clear and r4=0. Mode 11 with data 0x1 -> behaves as full write, r=0x00000001.

Source files
------------

// File: rtl/param_register_file.sv
// Parametrised general register file with write-merge modes, optional read
// bypass, optional hardwired-zero r0 and a per-register busy scoreboard.
module param_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   read_sel_1,
    input  logic [ADDR_WIDTH-1:0]   read_sel_2,
    output logic [DATA_WIDTH-1:0]   read_data_1,
    output logic [DATA_WIDTH-1:0]   read_data_2,
    output logic                    read_busy_1,
    output logic                    read_busy_2,
    input  logic                    RegWrite,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [1:0]              write_mode,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    reserve,
    input  logic [ADDR_WIDTH-1:0]   reserve_address,
    output logic                    busy_any
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned HALF   = DATA_WIDTH / 2;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned NPORTS = 2;

    localparam logic [1:0] MODE_FULL  = 2'b00;
    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_BYTE  = 2'b10;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic [DATA_WIDTH-1:0] old_wr;
    logic [DATA_WIDTH-1:0] merged;
    logic                  wr_zero_hit;
    logic                  rsv_zero_hit;
    logic                  wr_commit;
    logic                  rsv_commit;

    logic [ADDR_WIDTH-1:0] rsel  [NPORTS];
    logic [DATA_WIDTH-1:0] rdata [NPORTS];

    assign wr_zero_hit  = ZERO_REG && (write_address == '0);
    assign rsv_zero_hit = ZERO_REG && (reserve_address == '0);
    assign wr_commit    = RegWrite && !rst && !wr_zero_hit;
    assign rsv_commit   = reserve && !rst && !rsv_zero_hit;

    assign old_wr = regs_q[write_address];

    // Merge the incoming data with the current contents of the target.
    always_comb begin
        merged = write_data;
        unique case (write_mode)
            MODE_UPPER: merged = {write_data[HALF-1:0], old_wr[HALF-1:0]};
            MODE_BYTE: begin
                merged = old_wr;
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (byte_en[k]) begin
                        merged[k*8 +: 8] = write_data[k*8 +: 8];
                    end
                end
            end
            MODE_FULL: merged = write_data;
            default:   merged = write_data;
        endcase
    end

    // Reserve is applied after the write clear so a same-cycle reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (RegWrite) begin
            busy_d[write_address] = 1'b0;
        end
        if (rsv_commit) begin
            busy_d[reserve_address] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_commit) begin
                regs_q[write_address] <= merged;
            end
            busy_q <= busy_d;
        end
    end

    assign rsel[0] = read_sel_1;
    assign rsel[1] = read_sel_2;

    // Read ports: array value, optional bypass of the in-flight write, r0 forced to zero.
    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            rdata[p] = regs_q[rsel[p]];
            if (BYPASS && wr_commit && (write_address == rsel[p])) begin
                rdata[p] = merged;
            end
            if (ZERO_REG && (rsel[p] == '0)) begin
                rdata[p] = '0;
            end
        end
    end

    assign read_data_1 = rdata[0];
    assign read_data_2 = rdata[1];
    assign read_busy_1 = busy_q[read_sel_1];
    assign read_busy_2 = busy_q[read_sel_2];
    assign busy_any    = |busy_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default build plus ZERO_REG=0 and
// BYPASS=0 variants sharing one stimulus bus.
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  read_sel_1, read_sel_2;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [1:0]  write_mode;
    logic [3:0]  byte_en;
    logic        reserve;
    logic [4:0]  reserve_address;

    logic [31:0] d_rd1, d_rd2, z_rd1, z_rd2, b_rd1, b_rd2;
    logic        d_rb1, d_rb2, z_rb1, z_rb2, b_rb1, b_rb2;
    logic        d_any, z_any, b_any;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_register_file u_dut (
        .clk(clk), .rst(rst),
        .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
        .read_data_1(d_rd1), .read_data_2(d_rd2),
        .read_busy_1(d_rb1), .read_busy_2(d_rb2),
        .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .write_mode(write_mode), .byte_en(byte_en),
        .reserve(reserve), .reserve_address(reserve_address),
        .busy_any(d_any)
    );

    param_register_file #(.ZERO_REG(1'b0)) u_nz (
        .clk(clk), .rst(rst),
        .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
        .read_data_1(z_rd1), .read_data_2(z_rd2),
        .read_busy_1(z_rb1), .read_busy_2(z_rb2),
        .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .write_mode(write_mode), .byte_en(byte_en),
        .reserve(reserve), .reserve_address(reserve_address),
        .busy_any(z_any)
    );

    param_register_file #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst),
        .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
        .read_data_1(b_rd1), .read_data_2(b_rd2),
        .read_busy_1(b_rb1), .read_busy_2(b_rb2),
        .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .write_mode(write_mode), .byte_en(byte_en),
        .reserve(reserve), .reserve_address(reserve_address),
        .busy_any(b_any)
    );

    task automatic step();
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        reserve  = 1'b0;
        rst      = 1'b0;
        byte_en  = 4'h0;
        write_mode = 2'b00;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] m, input logic [3:0] be);
        RegWrite = 1'b1; write_address = a; write_data = d;
        write_mode = m; byte_en = be;
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            RegWrite = 1'b1; write_address = 5'($urandom_range(1, 31));
            write_data = $urandom; write_mode = 2'b00;
            reserve = 1'b1; reserve_address = 5'($urandom_range(1, 31));
            step();
        end
        rst = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            read_sel_1 = 5'(i);
            #1;
            n_tests++;
            if (d_rd1 !== 32'h0 || d_rb1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_clear r%0d: got data %h busy %b, expected 0/0", i, d_rd1, d_rb1);
            end
        end
        n_tests++;
        if (d_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_any: got %b expected 0", d_any);
        end
        wr(5'd5, 32'hDEADBEEF, 2'b00, 4'h0);
        read_sel_1 = 5'd5;
        #1;
        n_tests++;
        if (d_rd1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL first_write: got %h expected deadbeef", d_rd1);
        end
    endtask

    task automatic test_merge();
        read_sel_1 = 5'd7;
        wr(5'd7, 32'h12345678, 2'b00, 4'h0);
        wr(5'd7, 32'h0000ABCD, 2'b01, 4'h0);
        n_tests++;
        if (d_rd1 !== 32'hABCD5678) begin
            n_fail++;
            $display("FAIL merge_upper: got %h expected abcd5678", d_rd1);
        end
        wr(5'd7, 32'hFFFFFFFF, 2'b10, 4'b0101);
        n_tests++;
        if (d_rd1 !== 32'hABFF56FF) begin
            n_fail++;
            $display("FAIL merge_byte: got %h expected abff56ff", d_rd1);
        end
        reserve = 1'b1; reserve_address = 5'd7;
        step();
        wr(5'd7, 32'h00000000, 2'b10, 4'b0000);
        n_tests++;
        if (d_rd1 !== 32'hABFF56FF || d_rb1 !== 1'b0) begin
            n_fail++;
            $display("FAIL merge_byte_none: got %h busy %b expected abff56ff busy 0", d_rd1, d_rb1);
        end
    endtask

    task automatic test_zero_reg();
        read_sel_1 = 5'd0; read_sel_2 = 5'd0;
        RegWrite = 1'b1; write_address = 5'd0; write_data = 32'h55;
        reserve = 1'b1; reserve_address = 5'd0;
        #1;
        n_tests++;
        if (d_rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_bypass: got %h expected 0", d_rd1);
        end
        step();
        n_tests++;
        if (d_rd1 !== 32'h0 || d_rb1 !== 1'b0 || d_any !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: got %h busy %b any %b expected 0/0/0", d_rd1, d_rb1, d_any);
        end
        n_tests++;
        if (z_rd1 !== 32'h55 || z_rb1 !== 1'b1) begin
            n_fail++;
            $display("FAIL nonzero_r0: got %h busy %b expected 00000055 busy 1", z_rd1, z_rb1);
        end
        wr(5'd0, 32'h55, 2'b00, 4'h0);
    endtask

    task automatic test_bypass();
        wr(5'd3, 32'h11111111, 2'b00, 4'h0);
        read_sel_1 = 5'd3; read_sel_2 = 5'd3;
        RegWrite = 1'b1; write_address = 5'd3; write_data = 32'hCAFEF00D;
        #1;
        n_tests++;
        if (d_rd1 !== 32'hCAFEF00D || d_rd2 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL bypass_on: got %h/%h expected cafef00d", d_rd1, d_rd2);
        end
        n_tests++;
        if (b_rd1 !== 32'h11111111 || b_rd2 !== 32'h11111111) begin
            n_fail++;
            $display("FAIL bypass_off_before: got %h/%h expected 11111111", b_rd1, b_rd2);
        end
        step();
        n_tests++;
        if (b_rd1 !== 32'hCAFEF00D || b_rd2 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL bypass_off_after: got %h/%h expected cafef00d", b_rd1, b_rd2);
        end
        RegWrite = 1'b1; write_address = 5'd3; write_data = 32'h0000BEEF;
        write_mode = 2'b01;
        #1;
        n_tests++;
        if (d_rd1 !== 32'hBEEFF00D) begin
            n_fail++;
            $display("FAIL bypass_merged: got %h expected beeff00d", d_rd1);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (d_rd1 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL bypass_in_reset: got %h expected cafef00d", d_rd1);
        end
        step();
    endtask

    task automatic test_scoreboard();
        read_sel_1 = 5'd9; read_sel_2 = 5'd9;
        reserve = 1'b1; reserve_address = 5'd9;
        #1;
        n_tests++;
        if (d_rb1 !== 1'b0 || d_any !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_not_bypassed: got %b/%b expected 0/0", d_rb1, d_any);
        end
        step();
        n_tests++;
        if (d_rb1 !== 1'b1 || d_rb2 !== 1'b1 || d_any !== 1'b1) begin
            n_fail++;
            $display("FAIL reserve: got %b/%b/%b expected 1/1/1", d_rb1, d_rb2, d_any);
        end
        RegWrite = 1'b1; write_address = 5'd9; write_data = 32'h99;
        reserve = 1'b1; reserve_address = 5'd9;
        step();
        n_tests++;
        if (d_rb1 !== 1'b1 || d_rd1 !== 32'h99) begin
            n_fail++;
            $display("FAIL same_addr: got busy %b data %h expected 1/00000099", d_rb1, d_rd1);
        end
        RegWrite = 1'b1; write_address = 5'd9; write_data = 32'h9A;
        reserve = 1'b1; reserve_address = 5'd10;
        read_sel_2 = 5'd10;
        step();
        n_tests++;
        if (d_rb1 !== 1'b0 || d_rb2 !== 1'b1 || d_rd1 !== 32'h9A) begin
            n_fail++;
            $display("FAIL diff_addr: got %b/%b data %h expected 0/1/0000009a", d_rb1, d_rb2, d_rd1);
        end
        wr(5'd10, 32'hA, 2'b00, 4'h0);
        n_tests++;
        if (d_rb2 !== 1'b0 || d_any !== 1'b0) begin
            n_fail++;
            $display("FAIL write_clears: got %b any %b expected 0/0", d_rb2, d_any);
        end
    endtask

    task automatic test_reset_pending();
        read_sel_1 = 5'd4;
        wr(5'd4, 32'h44444444, 2'b00, 4'h0);
        reserve = 1'b1; reserve_address = 5'd4;
        step();
        rst = 1'b1; RegWrite = 1'b1; write_address = 5'd4; write_data = 32'h77;
        reserve = 1'b1; reserve_address = 5'd4;
        step();
        n_tests++;
        if (d_rb1 !== 1'b0 || d_rd1 !== 32'h0 || d_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending: got busy %b data %h any %b expected 0/0/0", d_rb1, d_rd1, d_any);
        end
        wr(5'd4, 32'hFFFFFFFF, 2'b00, 4'h0);
        wr(5'd4, 32'h00000001, 2'b11, 4'b1010);
        n_tests++;
        if (d_rd1 !== 32'h00000001) begin
            n_fail++;
            $display("FAIL mode11_full: got %h expected 00000001", d_rd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; RegWrite = 1'b0; reserve = 1'b0;
        read_sel_1 = '0; read_sel_2 = '0; write_address = '0;
        write_data = '0; write_mode = 2'b00; byte_en = 4'h0;
        reserve_address = '0;
        step();
        test_reset();
        test_merge();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
